// File: rtl/skew_feeder_pkg.sv
// Shared definitions for the systolic-engine operand feeders.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package skew_feeder_pkg;

   localparam int ENG_DATA_WIDTH = 32;
   localparam int ENG_BUS_WIDTH  = 64;
   localparam int ENG_MAX_DIM    = ENG_BUS_WIDTH / ENG_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_PEER = 2'd2,
      ST_STREAM    = 2'd3
   } state_t;

   // B mode: lane = column, A mode: lane = row
   localparam logic MODE_B = 1'b0;
   localparam logic MODE_A = 1'b1;

endpackage

// File: rtl/skew_lane_mux.sv
// Selects one lane's element of the skewed stream from the stored matrix.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
// Ports: mem (stored matrix, mem[row][col]), t (step), lane (lane index),
//        depth/lanes (D/L for the current mode), mode, elem (selected element or 0).
module skew_lane_mux
   import skew_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = ENG_DATA_WIDTH,
   parameter int MAX_DIM    = ENG_MAX_DIM,
   parameter int CNT_W      = 4
) (
   input  logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] mem,
   input  logic [CNT_W-1:0]                                 t,
   input  logic [CNT_W-1:0]                                 lane,
   input  logic [CNT_W-1:0]                                 depth,
   input  logic [CNT_W-1:0]                                 lanes,
   input  logic                                             mode,
   output logic [DATA_WIDTH-1:0]                            elem
);

   localparam int IW = $clog2(MAX_DIM);

   logic [CNT_W-1:0] idx;
   logic [IW-1:0]    r_i;
   logic [IW-1:0]    l_i;

   // idx wraps when t < lane; the t >= lane guard below discards that case.
   assign idx = t - lane;
   assign r_i = idx[IW-1:0];
   assign l_i = lane[IW-1:0];

   always_comb begin
      elem = '0;
      if ((t >= lane) && (idx < depth) && (lane < lanes)) begin
         if (mode == MODE_A) begin
            elem = mem[l_i][r_i];
         end else begin
            elem = mem[r_i][l_i];
         end
      end
   end

endmodule

// File: rtl/skew_feeder.sv
// Loads an operand matrix row by row, then streams it as a skewed zero-padded vector sequence.
// Latency: first vector one cycle after peer_loaded is sampled in WAIT_PEER; one step per accepted cycle.
// Backpressure: out_ready low holds the registered vector and step counter, no bubble.
// Ports: clk, reset (async active-low), clear (sync abort), start + cfg_rows/cfg_cols/cfg_mode,
//        wr_en + bus (row load), peer_loaded, out_ready; vector, out_valid, loaded,
//        stream_done (pulse), cfg_err (pulse).
module skew_feeder
   import skew_feeder_pkg::*;
#(
   parameter  int DATA_WIDTH = ENG_DATA_WIDTH,
   parameter  int BUS_WIDTH  = ENG_BUS_WIDTH,
   parameter  int CNT_W      = 4,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          start,
   input  logic [CNT_W-1:0]              cfg_rows,
   input  logic [CNT_W-1:0]              cfg_cols,
   input  logic                          cfg_mode,
   input  logic                          wr_en,
   input  logic [BUS_WIDTH-1:0]          bus,
   input  logic                          peer_loaded,
   input  logic                          out_ready,
   output logic [DATA_WIDTH*MAX_DIM-1:0] vector,
   output logic                          out_valid,
   output logic                          loaded,
   output logic                          stream_done,
   output logic                          cfg_err
);

   localparam int IW = $clog2(MAX_DIM);

   state_t state, state_nxt;

   logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] mem;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]              row_wdat;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]              lane_vec;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]              vec_q;

   logic [CNT_W-1:0] rows_q, cols_q, row_cnt, t_cnt;
   logic             mode_q;
   logic [CNT_W-1:0] depth, lanes, t_last, t_sel;
   logic             cfg_bad, row_last, step_last;
   logic             go_load, go_write, go_stream, go_step, go_done, go_err;

   assign depth  = (mode_q == MODE_A) ? cols_q : rows_q;
   assign lanes  = (mode_q == MODE_A) ? rows_q : cols_q;
   // Last step index is D + MAX_DIM - 2; the MAX_DIM term keeps both feeders the same length.
   assign t_last    = depth + CNT_W'(MAX_DIM - 2);
   assign step_last = (t_cnt == t_last);
   assign row_last  = (row_cnt == rows_q - CNT_W'(1));

   // Lane muxes look one step ahead so the vector register loads the step about to be shown.
   assign t_sel = (state == ST_STREAM) ? t_cnt + CNT_W'(1) : '0;

   assign cfg_bad = (cfg_rows == '0) || (cfg_rows > CNT_W'(MAX_DIM)) ||
                    (cfg_cols == '0) || (cfg_cols > CNT_W'(MAX_DIM));

   always_comb begin
      row_wdat = '0;
      for (int c = 0; c < MAX_DIM; c++) begin
         if (CNT_W'(c) < cols_q) begin
            row_wdat[c] = bus[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar l = 0; l < MAX_DIM; l++) begin : g_lane
      skew_lane_mux #(
         .DATA_WIDTH (DATA_WIDTH),
         .MAX_DIM    (MAX_DIM),
         .CNT_W      (CNT_W)
      ) u_mux (
         .mem   (mem),
         .t     (t_sel),
         .lane  (CNT_W'(l)),
         .depth (depth),
         .lanes (lanes),
         .mode  (mode_q),
         .elem  (lane_vec[l])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      go_load   = 1'b0;
      go_write  = 1'b0;
      go_stream = 1'b0;
      go_step   = 1'b0;
      go_done   = 1'b0;
      go_err    = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_bad) begin
                     go_err = 1'b1;
                  end else begin
                     go_load   = 1'b1;
                     state_nxt = ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  go_write = 1'b1;
                  if (row_last) begin
                     state_nxt = ST_WAIT_PEER;
                  end
               end
            end
            ST_WAIT_PEER: begin
               if (peer_loaded) begin
                  go_stream = 1'b1;
                  state_nxt = ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (out_valid && out_ready) begin
                  if (step_last) begin
                     go_done   = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     go_step = 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem         <= '0;
         rows_q      <= '0;
         cols_q      <= '0;
         mode_q      <= MODE_B;
         row_cnt     <= '0;
         t_cnt       <= '0;
         vec_q       <= '0;
         out_valid   <= 1'b0;
         loaded      <= 1'b0;
         stream_done <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         stream_done <= go_done;
         cfg_err     <= go_err;
         if (clear) begin
            vec_q     <= '0;
            out_valid <= 1'b0;
            loaded    <= 1'b0;
         end
         if (go_load) begin
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            mode_q  <= cfg_mode;
            row_cnt <= '0;
            mem     <= '0;
         end
         if (go_write) begin
            mem[row_cnt[IW-1:0]] <= row_wdat;
            row_cnt              <= row_cnt + CNT_W'(1);
            if (row_last) begin
               loaded <= 1'b1;
            end
         end
         if (go_stream) begin
            t_cnt     <= '0;
            vec_q     <= lane_vec;
            out_valid <= 1'b1;
         end
         if (go_step) begin
            t_cnt <= t_cnt + CNT_W'(1);
            vec_q <= lane_vec;
         end
         if (go_done) begin
            vec_q     <= '0;
            out_valid <= 1'b0;
            loaded    <= 1'b0;
         end
      end
   end

   assign vector = vec_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: one instance at MAX_DIM=2 and one at MAX_DIM=4 share the stimulus.
// Latency: n/a.
// Backpressure: out_ready is driven low in the stall sequence.
module tb_skew_feeder;
   import skew_feeder_pkg::*;

   logic         clk = 1'b0;
   logic         reset, clear, start, mode, wr_en, peer_loaded, out_ready;
   logic [3:0]   cfg_rows, cfg_cols;
   logic [127:0] bus;
   logic [ENG_MAX_DIM*32-1:0] vec2;
   logic [127:0] vec4;
   logic         ov2, ld2, sd2, ce2, ov4, ld4, sd4, ce4;
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   skew_feeder #(.DATA_WIDTH(32), .BUS_WIDTH(ENG_BUS_WIDTH), .CNT_W(4)) u_dut2 (
      .clk(clk), .reset(reset), .clear(clear), .start(start),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_mode(mode),
      .wr_en(wr_en), .bus(bus[63:0]), .peer_loaded(peer_loaded), .out_ready(out_ready),
      .vector(vec2), .out_valid(ov2), .loaded(ld2), .stream_done(sd2), .cfg_err(ce2)
   );

   skew_feeder #(.DATA_WIDTH(32), .BUS_WIDTH(128), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .clear(clear), .start(start),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_mode(mode),
      .wr_en(wr_en), .bus(bus), .peer_loaded(peer_loaded), .out_ready(out_ready),
      .vector(vec4), .out_valid(ov4), .loaded(ld4), .stream_done(sd4), .cfg_err(ce4)
   );

   typedef struct {
      logic         use4;
      logic         md;
      logic [3:0]   rows;
      logic [3:0]   cols;
      logic [127:0] r0;
      logic [127:0] r1;
      int           steps;
      logic [127:0] exp [5];
   } case_t;

   case_t cases [4];

   function automatic logic [127:0] v4(input int a, input int b, input int c, input int d);
      return {d[31:0], c[31:0], b[31:0], a[31:0]};
   endfunction

   function automatic logic [127:0] cur_vec(input logic use4);
      return use4 ? vec4 : {64'b0, vec2};
   endfunction

   // {out_valid, loaded, stream_done, cfg_err}
   function automatic logic [3:0] flags(input logic use4);
      return use4 ? {ov4, ld4, sd4, ce4} : {ov2, ld2, sd2, ce2};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic load_matrix(input logic use4, input logic md, input logic [3:0] rows,
                              input logic [3:0] cols, input logic [127:0] r0, input logic [127:0] r1);
      cfg_rows = rows;
      cfg_cols = cols;
      mode     = md;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("load entered, not loaded", {124'b0, flags(use4)}, 128'h0);
      wr_en = 1'b1;
      bus   = r0;
      tick();
      wr_en = 1'b0;
      bus   = '1;
      tick();
      chk("load hold cycle", {124'b0, flags(use4)}, (rows == 4'd2) ? 128'h0 : 128'h4);
      if (rows == 4'd2) begin
         wr_en = 1'b1;
         bus   = r1;
         tick();
         wr_en = 1'b0;
      end
      chk("loaded level", {124'b0, flags(use4)}, 128'h4);
   endtask

   task automatic stream_run(input logic use4, input int steps, input logic [127:0] exp [5]);
      tick();
      chk("wait peer, no valid", {124'b0, flags(use4)}, 128'h4);
      chk("wait peer, vector zero", cur_vec(use4), 128'h0);
      peer_loaded = 1'b1;
      tick();
      peer_loaded = 1'b0;
      for (int s = 0; s < steps; s++) begin
         chk($sformatf("step %0d vector", s), cur_vec(use4), exp[s]);
         chk($sformatf("step %0d flags", s), {124'b0, flags(use4)}, 128'hC);
         tick();
      end
      chk("after stream vector", cur_vec(use4), 128'h0);
      chk("stream_done pulse", {124'b0, flags(use4)}, 128'h2);
      tick();
      chk("stream_done cleared", {124'b0, flags(use4)}, 128'h0);
   endtask

   logic [127:0] ex [5];

   initial begin
      reset = 1'b0; clear = 1'b0; start = 1'b0; mode = MODE_B; wr_en = 1'b0;
      peer_loaded = 1'b0; out_ready = 1'b1; cfg_rows = '0; cfg_cols = '0; bus = '0;

      cases[0].use4 = 1'b0; cases[0].md = MODE_B; cases[0].rows = 4'd2; cases[0].cols = 4'd2;
      cases[0].r0 = {64'hFFFF_0000_FFFF_0000, 32'd2, 32'd1};
      cases[0].r1 = {64'h1234_5678_9ABC_DEF0, 32'd4, 32'd3};
      cases[0].steps = 3;
      cases[0].exp[0] = v4(1,0,0,0); cases[0].exp[1] = v4(3,2,0,0); cases[0].exp[2] = v4(0,4,0,0);
      cases[0].exp[3] = '0; cases[0].exp[4] = '0;

      cases[1] = cases[0];
      cases[1].md = MODE_A;
      cases[1].exp[1] = v4(2,3,0,0);

      cases[2].use4 = 1'b1; cases[2].md = MODE_B; cases[2].rows = 4'd2; cases[2].cols = 4'd3;
      cases[2].r0 = {32'hDEAD_BEEF, 32'd3, 32'd2, 32'd1};
      cases[2].r1 = {32'hCAFE_F00D, 32'd6, 32'd5, 32'd4};
      cases[2].steps = 5;
      cases[2].exp[0] = v4(1,0,0,0); cases[2].exp[1] = v4(4,2,0,0); cases[2].exp[2] = v4(0,5,3,0);
      cases[2].exp[3] = v4(0,0,6,0); cases[2].exp[4] = v4(0,0,0,0);

      cases[3].use4 = 1'b1; cases[3].md = MODE_A; cases[3].rows = 4'd2; cases[3].cols = 4'd2;
      cases[3].r0 = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd2, 32'd1};
      cases[3].r1 = {32'hCAFE_F00D, 32'hCAFE_F00D, 32'd4, 32'd3};
      cases[3].steps = 5;
      cases[3].exp[0] = v4(1,0,0,0); cases[3].exp[1] = v4(2,3,0,0); cases[3].exp[2] = v4(0,4,0,0);
      cases[3].exp[3] = '0; cases[3].exp[4] = '0;

      #12;
      chk("reset flags dim2", {124'b0, flags(1'b0)}, 128'h0);
      chk("reset flags dim4", {124'b0, flags(1'b1)}, 128'h0);
      chk("reset vector dim2", cur_vec(1'b0), 128'h0);
      chk("reset vector dim4", cur_vec(1'b1), 128'h0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         load_matrix(cases[i].use4, cases[i].md, cases[i].rows, cases[i].cols, cases[i].r0, cases[i].r1);
         stream_run(cases[i].use4, cases[i].steps, cases[i].exp);
         pulse_clear();
      end

      // Stall at t=1 for two cycles: (3,2) visible three cycles, then (0,4).
      load_matrix(1'b0, MODE_B, 4'd2, 4'd2, cases[0].r0, cases[0].r1);
      peer_loaded = 1'b1;
      tick();
      peer_loaded = 1'b0;
      chk("stall t0", cur_vec(1'b0), v4(1,0,0,0));
      tick();
      out_ready = 1'b0;
      chk("stall t1 first", cur_vec(1'b0), v4(3,2,0,0));
      tick();
      chk("stall t1 held a", cur_vec(1'b0), v4(3,2,0,0));
      chk("stall valid held", {124'b0, flags(1'b0)}, 128'hC);
      tick();
      chk("stall t1 held b", cur_vec(1'b0), v4(3,2,0,0));
      out_ready = 1'b1;
      tick();
      chk("stall t2", cur_vec(1'b0), v4(0,4,0,0));
      tick();
      chk("stall done", {124'b0, flags(1'b0)}, 128'h2);
      pulse_clear();

      // clear at t=1, then a fresh single-row load.
      load_matrix(1'b0, MODE_B, 4'd2, 4'd2, cases[0].r0, cases[0].r1);
      peer_loaded = 1'b1;
      tick();
      peer_loaded = 1'b0;
      tick();
      chk("pre-clear t1", cur_vec(1'b0), v4(3,2,0,0));
      pulse_clear();
      chk("clear flags", {124'b0, flags(1'b0)}, 128'h0);
      chk("clear vector", cur_vec(1'b0), 128'h0);
      ex[0] = v4(7,0,0,0); ex[1] = v4(0,8,0,0); ex[2] = '0; ex[3] = '0; ex[4] = '0;
      load_matrix(1'b0, MODE_B, 4'd1, 4'd2, {64'h0, 32'd8, 32'd7}, 128'h0);
      stream_run(1'b0, 2, ex);
      pulse_clear();

      // Illegal configs: rows=0 on both, cols=3 only illegal at MAX_DIM=2.
      cfg_rows = 4'd0; cfg_cols = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err rows0 dim2", {124'b0, flags(1'b0)}, 128'h1);
      chk("cfg_err rows0 dim4", {124'b0, flags(1'b1)}, 128'h1);
      tick();
      chk("cfg_err one cycle", {124'b0, flags(1'b0)}, 128'h0);
      cfg_rows = 4'd1; cfg_cols = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err cols3 dim2", {124'b0, flags(1'b0)}, 128'h1);
      chk("cols3 legal dim4", {124'b0, flags(1'b1)}, 128'h0);
      pulse_clear();

      // start with clear in the same cycle: stays IDLE, later writes are ignored.
      cfg_rows = 4'd1; cfg_cols = 4'd2; start = 1'b1; clear = 1'b1;
      tick();
      start = 1'b0; clear = 1'b0; wr_en = 1'b1; bus = 128'h5;
      tick();
      tick();
      wr_en = 1'b0;
      chk("start+clear ignored", {124'b0, flags(1'b0)}, 128'h0);

      // Async reset during stream drops outputs without a clock edge.
      load_matrix(1'b0, MODE_B, 4'd2, 4'd2, cases[0].r0, cases[0].r1);
      peer_loaded = 1'b1;
      tick();
      peer_loaded = 1'b0;
      chk("pre-reset valid", {124'b0, flags(1'b0)}, 128'hC);
      #2 reset = 1'b0;
      #1;
      chk("async reset flags", {124'b0, flags(1'b0)}, 128'h0);
      chk("async reset vector", cur_vec(1'b0), 128'h0);
      #1 reset = 1'b1;
      tick();

      // Async reset mid-LOAD, then a full run recovers.
      cfg_rows = 4'd2; cfg_cols = 4'd2; mode = MODE_B; start = 1'b1;
      tick();
      start = 1'b0; wr_en = 1'b1; bus = cases[0].r0;
      tick();
      wr_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid-load reset flags", {124'b0, flags(1'b0)}, 128'h0);
      #1 reset = 1'b1;
      tick();
      load_matrix(cases[0].use4, cases[0].md, cases[0].rows, cases[0].cols, cases[0].r0, cases[0].r1);
      stream_run(cases[0].use4, cases[0].steps, cases[0].exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
